io_input_conditioner: RTL and testbench

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

---
 rtl/io_input_conditioner.sv | 123 ++++++++++++
 tb/tb_io_input_conditioner.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// Synchronises and debounces raw switch/button levels; derives press pulses, sticky events, change strobe.
// Latency: a steady raw change reaches the stable outputs DEB_CYCLES+2 edges after it is first sampled.
// Backpressure: none; outputs are level/pulse registers updated every cycle, no handshake.

module io_input_conditioner_deb #(
    parameter int           W          = 1,
    parameter int           DEB_CYCLES = 16,
    parameter logic [W-1:0] SYNC_IDLE  = '0,
    parameter bit           INVERT     = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_stable,
    output logic [W-1:0] o_accept
);
    localparam int            CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [W-1:0]         s1;
    logic [W-1:0]         s2;
    logic [W-1:0]         lvl;
    logic [W-1:0][CW-1:0] cnt;

    // Polarity is normalised after the synchroniser so the debouncer only sees active-high levels.
    assign lvl = INVERT ? ~s2 : s2;

    always_comb begin
        o_accept = '0;
        for (int i = 0; i < W; i++) begin
            o_accept[i] = (lvl[i] != o_stable[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1       <= SYNC_IDLE;
            s2       <= SYNC_IDLE;
            o_stable <= '0;
            cnt      <= '0;
        end else begin
            s1       <= i_raw;
            s2       <= s1;
            o_stable <= o_stable ^ o_accept;
            for (int i = 0; i < W; i++) begin
                if (lvl[i] == o_stable[i] || o_accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end
endmodule

module io_input_conditioner #(
    parameter int SW_W           = 32,
    parameter int BTN_W          = 4,
    parameter int DEB_CYCLES     = 16,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [SW_W-1:0]  i_io_sw,
    input  logic [BTN_W-1:0] i_io_btn,
    input  logic             i_clr_en,
    input  logic [BTN_W-1:0] i_clr_mask,
    output logic [SW_W-1:0]  o_sw_stable,
    output logic [BTN_W-1:0] o_btn_level,
    output logic [BTN_W-1:0] o_btn_press,
    output logic [BTN_W-1:0] o_btn_event,
    output logic             o_sw_change
);
    localparam logic [BTN_W-1:0] BTN_IDLE = {BTN_W{BTN_ACTIVE_LOW}};

    logic [SW_W-1:0]  sw_accept;
    logic [BTN_W-1:0] btn_accept;
    logic [BTN_W-1:0] btn_rise;
    logic [BTN_W-1:0] clr_gate;

    io_input_conditioner_deb #(
        .W          (SW_W),
        .DEB_CYCLES (DEB_CYCLES),
        .SYNC_IDLE  ({SW_W{1'b0}}),
        .INVERT     (1'b0)
    ) u_sw_deb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_raw    (i_io_sw),
        .o_stable (o_sw_stable),
        .o_accept (sw_accept)
    );

    io_input_conditioner_deb #(
        .W          (BTN_W),
        .DEB_CYCLES (DEB_CYCLES),
        .SYNC_IDLE  (BTN_IDLE),
        .INVERT     (BTN_ACTIVE_LOW)
    ) u_btn_deb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_raw    (i_io_btn),
        .o_stable (o_btn_level),
        .o_accept (btn_accept)
    );

    // An accepted change on a currently-released button is a press; releases are filtered out here.
    assign btn_rise = btn_accept & ~o_btn_level;
    assign clr_gate = i_clr_en ? i_clr_mask : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_btn_press <= '0;
            o_btn_event <= '0;
            o_sw_change <= 1'b0;
        end else begin
            o_btn_press <= btn_rise;
            // Set is OR-ed after the clear so a coincident press keeps the flag.
            o_btn_event <= (o_btn_event & ~clr_gate) | btn_rise;
            o_sw_change <= |sw_accept;
        end
    end
endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomised + directed bench; a window-based reference model predicts every cycle's outputs into a scoreboard.
module tb_io_input_conditioner;
    localparam int DEB = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_io_sw = '0;
    logic [3:0]  i_io_btn = 4'hf;
    logic        i_clr_en = 1'b0;
    logic [3:0]  i_clr_mask = '0;
    logic [31:0] o_sw_stable;
    logic [3:0]  o_btn_level;
    logic [3:0]  o_btn_press;
    logic [3:0]  o_btn_event;
    logic        o_sw_change;

    io_input_conditioner #(
        .SW_W(32), .BTN_W(4), .DEB_CYCLES(DEB), .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_io_sw     (i_io_sw),
        .i_io_btn    (i_io_btn),
        .i_clr_en    (i_clr_en),
        .i_clr_mask  (i_clr_mask),
        .o_sw_stable (o_sw_stable),
        .o_btn_level (o_btn_level),
        .o_btn_press (o_btn_press),
        .o_btn_event (o_btn_event),
        .o_sw_change (o_sw_change)
    );

    always #50 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] sw;
        logic [3:0]  lvl;
        logic [3:0]  press;
        logic [3:0]  evt;
        logic        change;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    // Reference model: a level is accepted once the last DEB synchronised samples all disagree with it.
    logic [31:0] m_sw_p1, m_sw_p2, m_sw_stable;
    logic [31:0] m_sw_win [DEB];
    logic [3:0]  m_bt_p1, m_bt_p2, m_bt_stable, m_evt, m_press;
    logic [3:0]  m_bt_win [DEB];
    logic        m_change;

    logic [31:0] cur_sw   = '0;
    logic [3:0]  cur_btn  = 4'hf;
    logic        cur_clr  = 1'b0;
    logic [3:0]  cur_mask = '0;
    logic        cur_rst  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] acc_sw;
        logic [3:0]  acc_bt;
        if (!cur_rst) begin
            m_sw_p1 = '0; m_sw_p2 = '0; m_sw_stable = '0;
            m_bt_p1 = 4'hf; m_bt_p2 = 4'hf; m_bt_stable = '0;
            for (int j = 0; j < DEB; j++) begin
                m_sw_win[j] = '0;
                m_bt_win[j] = '0;
            end
            m_evt = '0; m_press = '0; m_change = 1'b0;
        end else begin
            for (int j = DEB - 1; j > 0; j--) begin
                m_sw_win[j] = m_sw_win[j-1];
                m_bt_win[j] = m_bt_win[j-1];
            end
            m_sw_win[0] = m_sw_p2;
            m_bt_win[0] = ~m_bt_p2;
            acc_sw = '1;
            acc_bt = '1;
            for (int j = 0; j < DEB; j++) begin
                acc_sw &= m_sw_win[j] ^ m_sw_stable;
                acc_bt &= m_bt_win[j] ^ m_bt_stable;
            end
            m_change    = |acc_sw;
            m_sw_stable = m_sw_stable ^ acc_sw;
            m_press     = acc_bt & ~m_bt_stable;
            m_evt       = (m_evt & ~(cur_clr ? cur_mask : 4'h0)) | m_press;
            m_bt_stable = m_bt_stable ^ acc_bt;
            m_sw_p2 = m_sw_p1; m_sw_p1 = cur_sw;
            m_bt_p2 = m_bt_p1; m_bt_p1 = cur_btn;
        end
    endtask

    // Apply cur_* for the next edge, predict it, then return 10 units after that edge.
    task automatic step();
        exp_t e;
        i_io_sw    = cur_sw;
        i_io_btn   = cur_btn;
        i_clr_en   = cur_clr;
        i_clr_mask = cur_mask;
        i_rst      = cur_rst;
        model_edge();
        e.sw = m_sw_stable; e.lvl = m_bt_stable; e.press = m_press;
        e.evt = m_evt; e.change = m_change;
        exp_q.push_back(e);
        n_push++;
        #1;
        if (!cur_rst) begin
            chk("rst_sw_stable", o_sw_stable, 32'h0);
            chk("rst_btn_level", {28'h0, o_btn_level}, 32'h0);
            chk("rst_btn_event", {28'h0, o_btn_event}, 32'h0);
            chk("rst_sw_change", {31'h0, o_sw_change}, 32'h0);
        end
        @(posedge i_clk);
        #10;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_clk);
            #5;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pop++;
                chk("sw_stable", o_sw_stable, e.sw);
                chk("btn_level", {28'h0, o_btn_level}, {28'h0, e.lvl});
                chk("btn_press", {28'h0, o_btn_press}, {28'h0, e.press});
                chk("btn_event", {28'h0, o_btn_event}, {28'h0, e.evt});
                chk("sw_change", {31'h0, o_sw_change}, {31'h0, e.change});
            end
        end
    end

    initial begin : stim
        // Reset with a switch high and buttons idle, then release.
        cur_sw = 32'h01; cur_btn = 4'hf; cur_rst = 1'b0;
        run(3);
        cur_rst = 1'b1;
        run(5);
        chk("d_rel_sw_early", o_sw_stable, 32'h0);
        run(1);
        chk("d_rel_sw_accept", o_sw_stable, 32'h01);
        chk("d_rel_change", {31'h0, o_sw_change}, 32'h1);
        chk("d_rel_btn_level", {28'h0, o_btn_level}, 32'h0);
        run(1);
        chk("d_rel_change_once", {31'h0, o_sw_change}, 32'h0);

        // Switch 01 -> 03 held.
        cur_sw = 32'h03;
        run(5);
        chk("d_sw3_early", o_sw_stable, 32'h01);
        run(1);
        chk("d_sw3_accept", o_sw_stable, 32'h03);
        chk("d_sw3_change", {31'h0, o_sw_change}, 32'h1);
        run(20);
        chk("d_sw3_hold", o_sw_stable, 32'h03);

        // Three-cycle glitch on btn2 is rejected.
        cur_btn = 4'b1011;
        run(3);
        cur_btn = 4'hf;
        run(10);
        chk("d_glitch_level", {28'h0, o_btn_level}, 32'h0);
        chk("d_glitch_event", {28'h0, o_btn_event}, 32'h0);

        // btn0 press held 10 cycles.
        cur_btn = 4'b1110;
        run(5);
        chk("d_b0_early", {28'h0, o_btn_level}, 32'h0);
        run(1);
        chk("d_b0_level", {28'h0, o_btn_level}, 32'h1);
        chk("d_b0_press", {28'h0, o_btn_press}, 32'h1);
        chk("d_b0_event", {28'h0, o_btn_event}, 32'h1);
        run(1);
        chk("d_b0_press_once", {28'h0, o_btn_press}, 32'h0);
        run(3);
        cur_btn = 4'hf;
        run(8);
        chk("d_b0_released", {28'h0, o_btn_level}, 32'h0);
        chk("d_b0_sticky", {28'h0, o_btn_event}, 32'h1);

        // Build event = 0011, then clear bit0 on btn1's acceptance edge.
        cur_btn = 4'b1101;
        run(8);
        cur_btn = 4'hf;
        run(8);
        chk("d_evt_0011", {28'h0, o_btn_event}, 32'h3);
        cur_btn = 4'b1101;
        run(5);
        cur_clr = 1'b1; cur_mask = 4'b0001;
        run(1);
        chk("d_clr_b0_evt", {28'h0, o_btn_event}, 32'h2);
        chk("d_clr_b0_press", {28'h0, o_btn_press}, 32'h2);
        cur_clr = 1'b0;
        cur_btn = 4'hf;
        run(8);

        // Clear of btn1 coincident with its own press: set wins.
        cur_btn = 4'b1101;
        run(5);
        cur_clr = 1'b1; cur_mask = 4'b0010;
        run(1);
        chk("d_set_wins", {28'h0, o_btn_event}, 32'h2);
        cur_clr = 1'b0; cur_mask = 4'hf;
        run(2);
        chk("d_mask_ignored", {28'h0, o_btn_event}, 32'h2);
        cur_clr = 1'b1; cur_mask = 4'b0010;
        run(1);
        chk("d_clr_b1", {28'h0, o_btn_event}, 32'h0);
        cur_clr = 1'b0;
        cur_btn = 4'hf;
        run(8);

        // Reset mid-debounce of 03 -> 07.
        cur_sw = 32'h07;
        run(5);
        chk("d_mid_pending", o_sw_stable, 32'h03);
        cur_rst = 1'b0;
        run(2);
        cur_rst = 1'b1;
        run(5);
        chk("d_rearm_early", o_sw_stable, 32'h0);
        chk("d_rearm_nochg", {31'h0, o_sw_change}, 32'h0);
        run(1);
        chk("d_rearm_accept", o_sw_stable, 32'h07);
        chk("d_rearm_change", {31'h0, o_sw_change}, 32'h1);

        // Random traffic: sparse toggles produce both glitches and accepted changes.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(5) == 0) cur_sw ^= ($urandom & $urandom & $urandom);
            if ($urandom_range(4) == 0) cur_btn ^= 4'(1 << $urandom_range(3));
            cur_clr  = ($urandom_range(3) == 0);
            cur_mask = 4'($urandom);
            cur_rst  = ($urandom_range(399) != 0);
            step();
        end
        cur_rst = 1'b1;
        run(2);

        chk("scoreboard_drained", n_pop, n_push);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
